// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes engine: substitutes a 128-bit state LANES bytes per clock,
// forward or inverse S-box selected per block, valid/ready on both sides.

module sub_bytes_lane (
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  // Index 0 is the leftmost byte of each concatenation.
  localparam logic [0:255][7:0] FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:255][7:0] INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign dout = inv ? INV[din] : FWD[din];
endmodule

module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                           state;
  logic [CW-1:0]                    cnt;
  logic                             mode;
  logic [STEPS-1:0][LANES-1:0][7:0] work, work_nxt;
  logic [LANES-1:0][7:0]            lane_in, lane_out;
  logic                             last;

  // work[cnt] is the group of LANES bytes handled this step.
  assign lane_in = work[cnt];
  assign last    = (cnt == CW'(STEPS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sub_bytes_lane u_lane (
      .din  (lane_in[l]),
      .inv  (mode),
      .dout (lane_out[l])
    );
  end

  always_comb begin
    work_nxt      = work;
    work_nxt[cnt] = lane_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      work      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_state <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          // in_ready is the registered IDLE flag, so the rst cycle never accepts.
          if (in_ready && in_valid) begin
            work     <= in_state;
            mode     <= in_inv;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          work <= work_nxt;
          if (last) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            out_state <= work_nxt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq: S-box reference built from GF(2^8) inversion
// plus the affine map; directed, randomized and parameter-sweep checks.

module tb_sub_bytes_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [127:0] in_state, out_state;

  logic               sw_in_valid, sw_inv;
  logic [127:0]       sw_state;
  logic [3:0]         sw_in_ready, sw_out_valid, sw_busy;
  logic [3:0][127:0]  sw_out_state;
  localparam int SW_LAT [4] = '{16, 8, 2, 1};

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   ref_fwd [256];
  logic [7:0]   ref_inv [256];
  logic [127:0] exp_q [$];
  logic [127:0] bp_state [8];
  logic         bp_inv [8];
  logic [127:0] vec, e;
  int           lat, idx, got;

  localparam logic [127:0] V_SEQ = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] V_FWD = 128'h76abd7fe2b670130c56f6bf27b777c63;

  sub_bytes_seq #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_inv(in_inv), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    sub_bytes_seq #(.LANES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16)) u_sw (
      .clk(clk), .rst(rst), .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]),
      .in_state(sw_state), .in_inv(sw_inv), .out_valid(sw_out_valid[g]),
      .out_ready(1'b1), .out_state(sw_out_state[g]), .busy(sw_busy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);  // a^254 = a^-1, and 0 -> 0
    return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = inv ? ref_inv[s[8*i +: 8]] : ref_fwd[s[8*i +: 8]];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_block(input logic [127:0] s, input logic inv);
    int w = 0;
    while (!in_ready && w < 50) begin tick(); w++; end
    in_valid = 1'b1; in_state = s; in_inv = inv;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int l);
    l = 0;
    while (!out_valid && l < 40) begin tick(); l++; end
  endtask

  task automatic recv(input string tag, input logic [127:0] exp);
    check(tag, out_state, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, 128'(out_valid), 128'd0);
  endtask

  task automatic sweep(input string tag, input logic [127:0] s, input logic inv);
    int           l [4];
    logic [127:0] r [4];
    int           w = 0;
    for (int g = 0; g < 4; g++) begin l[g] = 0; r[g] = 'x; end
    while (sw_in_ready != 4'hf && w < 50) begin tick(); w++; end
    sw_in_valid = 1'b1; sw_state = s; sw_inv = inv;
    tick();
    sw_in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int g = 0; g < 4; g++)
        if (sw_out_valid[g] && l[g] == 0) begin l[g] = c; r[g] = sw_out_state[g]; end
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s_lat%0d", tag, g), 128'(l[g]), 128'(SW_LAT[g]));
      check($sformatf("%s_data%0d", tag, g), r[g], ref_sub(s, inv));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < 256; x++) begin
      ref_fwd[x] = sbox_math(8'(x));
      ref_inv[ref_fwd[x]] = 8'(x);
    end

    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_state = '0; out_ready = 1'b0;
    sw_in_valid = 1'b0; sw_inv = 1'b0; sw_state = '0;
    tick(); tick();
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_out_state", out_state, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 128'(in_ready), 128'd1);

    // Forward on 00..0F, then hold the result under back-pressure
    check("model_fwd_seq", ref_sub(V_SEQ, 1'b0), V_FWD);
    accept_block(V_SEQ, 1'b0);
    wait_out(lat);
    check("fwd_lat", 128'(lat), 128'd4);
    for (int c = 0; c < 3; c++) begin
      check("hold_vld", 128'(out_valid), 128'd1);
      check("hold_data", out_state, V_FWD);
      check("hold_in_ready", 128'(in_ready), 128'd0);
      check("hold_busy", 128'(busy), 128'd1);
      tick();
    end
    recv("fwd_data", V_FWD);
    check("post_in_ready", 128'(in_ready), 128'd1);
    check("post_busy", 128'(busy), 128'd0);

    accept_block(V_FWD, 1'b1); wait_out(lat); recv("inv_roundtrip", V_SEQ);
    accept_block({16{8'h63}}, 1'b1); wait_out(lat); recv("inv_all63", 128'd0);
    accept_block({16{8'hff}}, 1'b0); wait_out(lat); recv("fwd_allff", {16{8'h16}});

    // Inputs changed after accept must not affect the block in flight
    vec = {$urandom, $urandom, $urandom, $urandom};
    accept_block(vec, 1'b0);
    in_inv = 1'b1; in_state = ~vec;
    tick();
    in_inv = 1'b0;
    wait_out(lat);
    recv("midbusy_change", ref_sub(vec, 1'b0));

    // Continuous in_valid with random out_ready
    for (int i = 0; i < 8; i++) begin
      bp_state[i] = {$urandom, $urandom, $urandom, $urandom};
      bp_inv[i]   = 1'($urandom_range(0, 1));
    end
    idx = 0; got = 0;
    for (int c = 0; c < 400 && (idx < 8 || exp_q.size() != 0); c++) begin
      in_valid = (idx < 8);
      if (idx < 8) begin in_state = bp_state[idx]; in_inv = bp_inv[idx]; end
      out_ready = 1'($urandom_range(0, 1));
      check("bp_ready_xor_busy", 128'(in_ready ^ busy), 128'd1);
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(bp_state[idx], bp_inv[idx]));
        idx++;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        check("bp_data", out_state, e);
        got++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check("bp_no_dup", 128'(out_valid), 128'd0);
      tick();
    end
    out_ready = 1'b0;
    check("bp_count", 128'(got), 128'd8);

    // Reset during the second BUSY step
    accept_block(V_SEQ, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_out_state", out_state, 128'd0);
    check("midrst_busy", 128'(busy), 128'd0);
    tick();
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    check("midrst_out_valid2", 128'(out_valid), 128'd0);
    accept_block(V_FWD, 1'b1); wait_out(lat);
    check("midrst_next_lat", 128'(lat), 128'd4);
    recv("midrst_next_data", V_SEQ);

    // Every byte value through both tables
    for (int k = 0; k < 16; k++)
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < 16; i++) vec[8*i +: 8] = 8'(16*k + i);
        accept_block(vec, 1'(m));
        wait_out(lat);
        check($sformatf("exh_lat_%0d_%0d", k, m), 128'(lat), 128'd4);
        recv($sformatf("exh_data_%0d_%0d", k, m), ref_sub(vec, 1'(m)));
      end

    // LANES = 1, 2, 8, 16
    sweep("sw_fwd_seq", V_SEQ, 1'b0);
    sweep("sw_inv_fwd", V_FWD, 1'b1);
    sweep("sw_fwd_ff", {16{8'hff}}, 1'b0);
    sweep("sw_inv_63", {16{8'h63}}, 1'b1);
    check("sw_idle_busy", 128'(sw_busy), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
- Sequential, lane-parametrised AES byte-substitution engine. It is the successor to the combinational forward/inverse substitution used in the round datapath.
- It substitutes a 128-bit state LANES bytes per clock, with a run-time selectable forward or inverse S-box.
- It uses valid/ready handshakes on both sides, so the round controller can trade area for latency.
- It sits between AddRoundKey and ShiftRows in the iterative cipher core.

Parameters:
- LANES, 4, number of S-box lookups per cycle; legal values 1, 2, 4, 8, 16 (elaboration error otherwise).
- STEPS, 16/LANES, derived localparam; BUSY cycles per block.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_state  in  128  state; byte i at bits [8i+7:8i].
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled at accept.
- out_valid  out  1  substituted block available.
- out_ready  in  1  downstream accepts result.
- out_state  out  128  substituted state; same byte order as in_state.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset values: in_ready=0 during the rst cycle, then 1 in IDLE. out_valid=0, out_state=0, busy=0, step counter=0, mode register=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid=1, capture in_state into the work register, latch in_inv, set counter=0, go to BUSY.
  - BUSY: each cycle, replace bytes [counter*LANES .. counter*LANES+LANES-1] of the work register with sbox/inv_sbox of the same bytes, then counter++. After the step with counter==STEPS-1, go to DONE.
  - DONE: out_valid=1 and out_state=work register, held stable until out_ready=1. On the handshake cycle, go to IDLE with out_valid=0 next cycle.
- Latency: accept edge to out_valid is STEPS cycles. LANES=16 gives 1 cycle; LANES=1 gives 16 cycles.
- Throughput: one block per STEPS+2 cycles with out_ready tied high. No accept while BUSY or DONE, and in_ready=0 there.
- in_state and in_inv changes after accept have no effect on the block in flight.
- out_ready=1 while not in DONE is ignored. in_valid while in_ready=0 is ignored; the source must hold it.
- S-box contents are the FIPS-197 forward and inverse tables. Lookups are pure combinational ROM with LANES copies of each table. Mode mux is per lane.
- Counter width is clog2(STEPS), minimum 1. It never exceeds STEPS-1.
- rst asserted in any state: immediate return to IDLE next edge. The in-flight block is discarded, out_valid=0 and outputs take reset values. rst takes priority over a simultaneous handshake.
- No combinational path from in_valid/out_ready to in_ready/out_valid. All outputs are registered or decoded from the state register.

Test Plan:
- Forward, LANES=4: in_state bytes 0..15 = 8'h00..8'h0F, in_inv=0 → after 4 cycles out_state bytes 0..15 = 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76; out_valid held 3 cycles with out_ready=0, data stable.
- Inverse round-trip: feed the previous output with in_inv=1 → out_state bytes = 00..0F. Also check all-63 input, inverse → 128'h0, and 128'hFF..FF forward → 128'h1616..16.
- Parameter sweep LANES=1,2,8,16 on the same vectors → identical results; out_valid exactly 16, 8, 2, 1 cycles after the accept edge.
- Back-pressure/handshake: in_valid held high continuously with out_ready random. Each block is accepted only when in_ready=1, with no block dropped or duplicated. in_inv toggled mid-BUSY does not change the result.
- Reset mid-operation: assert rst on BUSY step 2 → next cycle IDLE, in_ready=1, out_valid=0, out_state=0. The next block completes correctly.
- Exhaustive lookup: 16 blocks covering byte values 0x00..0xFF in both modes, compared against a reference model → zero mismatches.
